// File: rtl/ram_clr.sv
// Simple dual-port RAM with byte strobes and a zeroing clear engine; 1-cycle read, and access is locked out while busy.
// Define RAM_BYPASS_EN to forward a same-cycle, same-address write into the read (otherwise read-before-write).
module ram_clr #(
   parameter int  RAM_SIZE   = 64,
   parameter int  DATA_WIDTH = 8,
   parameter int  BYTE_WIDTH = 8,
   localparam int ADDR_WIDTH = $clog2(RAM_SIZE),
   localparam int NUM_BYTES  = DATA_WIDTH / BYTE_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   output logic                  busy,
   input  logic                  w_enable,
   input  logic [ADDR_WIDTH-1:0] w_addr,
   input  logic [NUM_BYTES-1:0]  w_strb,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  r_enable,
   input  logic [ADDR_WIDTH-1:0] r_addr,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  r_valid
);

   typedef enum logic {CLEAR, IDLE} state_t;

   localparam logic [ADDR_WIDTH:0]   SIZE_EXT  = (ADDR_WIDTH + 1)'(RAM_SIZE);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_SIZE - 1);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic                  r_valid_q, r_valid_d;

   logic [DATA_WIDTH-1:0] mem [RAM_SIZE];

   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [NUM_BYTES-1:0]  mem_wstrb;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  w_in_range;
   logic                  r_in_range;
   logic [DATA_WIDTH-1:0] rd_word;

   // Non-power-of-two sizes leave a hole at the top of the address space.
   assign w_in_range = ({1'b0, w_addr} < SIZE_EXT);
   assign r_in_range = ({1'b0, r_addr} < SIZE_EXT);

   always_comb begin
      rd_word = '0;
      if (r_in_range) begin
         rd_word = mem[r_addr];
`ifdef RAM_BYPASS_EN
         if (w_enable && w_in_range && (w_addr == r_addr)) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
               if (w_strb[i]) begin
                  rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = data_in[i*BYTE_WIDTH +: BYTE_WIDTH];
               end
            end
         end
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      data_out_d = data_out_q;
      r_valid_d  = 1'b0;
      mem_we     = 1'b0;
      mem_waddr  = w_addr;
      mem_wstrb  = w_strb;
      mem_wdata  = data_in;
      case (state_q)
         CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wstrb = '1;
            mem_wdata = '0;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) begin
               state_d = IDLE;
            end
         end
         IDLE: begin
            if (clear) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end else begin
               mem_we = w_enable && w_in_range;
               if (r_enable) begin
                  r_valid_d  = 1'b1;
                  data_out_d = rd_word;
               end
            end
         end
         default: state_d = CLEAR;
      endcase
      // Reset itself never writes the array; the clear pass that follows does.
      if (rst) begin
         mem_we = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= CLEAR;
         cnt_q      <= '0;
         data_out_q <= '0;
         r_valid_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         data_out_q <= data_out_d;
         r_valid_q  <= r_valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < NUM_BYTES; i++) begin
            if (mem_wstrb[i]) begin
               mem[mem_waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
   end

   assign busy     = (state_q == CLEAR);
   assign data_out = data_out_q;
   assign r_valid  = r_valid_q;

endmodule

// File: tb/tb_ram_clr.sv
// Bench for ram_clr (48 words x 32 bits): directed table, clear/reset sequences, random traffic vs. a reference model.
module tb_ram_clr;
   localparam int RAM_SIZE = 48;
   localparam int DW = 32;
   localparam int BW = 8;
   localparam int AW = 6;
   localparam int NB = 4;
`ifdef RAM_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst, clear, busy, w_enable, r_enable, r_valid;
   logic [AW-1:0] w_addr, r_addr;
   logic [NB-1:0] w_strb;
   logic [DW-1:0] data_in, data_out;

   always #5 clk = ~clk;

   ram_clr #(.RAM_SIZE(RAM_SIZE), .DATA_WIDTH(DW), .BYTE_WIDTH(BW)) dut (
      .clk(clk), .rst(rst), .clear(clear), .busy(busy),
      .w_enable(w_enable), .w_addr(w_addr), .w_strb(w_strb), .data_in(data_in),
      .r_enable(r_enable), .r_addr(r_addr), .data_out(data_out), .r_valid(r_valid)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference: word array, remaining clear edges, and the expected read port.
   logic [DW-1:0] m_mem [RAM_SIZE];
   int            m_left = RAM_SIZE;
   logic          m_rv   = 1'b0;
   logic [DW-1:0] m_dout = '0;

   typedef struct {
      logic          clr;
      logic          we;
      logic [AW-1:0] wa;
      logic [NB-1:0] st;
      logic [DW-1:0] di;
      logic          re;
      logic [AW-1:0] ra;
      logic          exp_rv;
      logic [DW-1:0] exp_do;
   } vec_t;

   vec_t vt[$];

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic model_zero();
      for (int k = 0; k < RAM_SIZE; k++) m_mem[k] = '0;
   endtask

   task automatic model_edge();
      logic [DW-1:0] old_w, new_w;
      logic          wr_ok;
      if (rst) begin
         m_left = RAM_SIZE;
         m_rv   = 1'b0;
         m_dout = '0;
         model_zero();
      end else if (m_left > 0) begin
         m_left--;
         m_rv = 1'b0;
      end else if (clear) begin
         m_left = RAM_SIZE;
         m_rv   = 1'b0;
         model_zero();
      end else begin
         old_w = '0;
         if (int'(r_addr) < RAM_SIZE) old_w = m_mem[r_addr];
         wr_ok = w_enable && (int'(w_addr) < RAM_SIZE);
         if (wr_ok) begin
            new_w = m_mem[w_addr];
            for (int i = 0; i < NB; i++)
               if (w_strb[i]) new_w[i*BW +: BW] = data_in[i*BW +: BW];
            m_mem[w_addr] = new_w;
         end
         m_rv = r_enable;
         if (r_enable) m_dout = (BYP && wr_ok && (w_addr == r_addr)) ? m_mem[r_addr] : old_w;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("busy", DW'(busy), DW'(m_left > 0));
      chk("r_valid", DW'(r_valid), DW'(m_rv));
      chk("data_out", data_out, m_dout);
   endtask

   task automatic set_in(input logic clr, input logic we, input logic [AW-1:0] wa, input logic [NB-1:0] st,
                         input logic [DW-1:0] di, input logic re, input logic [AW-1:0] ra);
      clear = clr; w_enable = we; w_addr = wa; w_strb = st; data_in = di; r_enable = re; r_addr = ra;
   endtask

   function automatic vec_t mk(input logic clr, input logic we, input logic [AW-1:0] wa, input logic [NB-1:0] st,
                               input logic [DW-1:0] di, input logic re, input logic [AW-1:0] ra,
                               input logic erv, input logic [DW-1:0] edo);
      vec_t v;
      v.clr = clr; v.we = we; v.wa = wa; v.st = st; v.di = di; v.re = re; v.ra = ra;
      v.exp_rv = erv; v.exp_do = edo;
      return v;
   endfunction

   task automatic count_busy(output int n);
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         n++;
         step();
      end
   endtask

   task automatic read_all_zero();
      for (int a = 0; a < RAM_SIZE; a++) begin
         set_in(1'b0, 1'b0, '0, '0, '0, 1'b1, AW'(a));
         step();
         chk("sweep_rv", DW'(r_valid), 32'd1);
         chk("sweep_zero", data_out, 32'd0);
      end
      set_in(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
   endtask

   initial begin
      int n;
      rst = 1'b1;
      set_in(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
      step();
      step();
      chk("rst_busy", DW'(busy), 32'd1);
      chk("rst_rv", DW'(r_valid), 32'd0);
      chk("rst_dout", data_out, 32'd0);

      rst = 1'b0;
      count_busy(n);
      chk("init_clear_len", DW'(n), DW'(RAM_SIZE));
      read_all_zero();

      // {clr, we, wa, strb, din, re, ra, exp_rv, exp_dout}; results appear after the same record's edge
      vt.push_back(mk(0, 1, 3,  4'hF, 32'h000000A5, 0, 0,  0, 32'h0));
      vt.push_back(mk(0, 0, 0,  4'h0, 32'h0,        1, 3,  1, 32'h000000A5));
      vt.push_back(mk(0, 1, 7,  4'hF, 32'h11223344, 0, 0,  0, 32'h0));
      vt.push_back(mk(0, 1, 7,  4'h5, 32'hAABBCCDD, 0, 0,  0, 32'h0));
      vt.push_back(mk(0, 0, 0,  4'h0, 32'h0,        1, 7,  1, 32'h11BB33DD));
      vt.push_back(mk(0, 1, 7,  4'h0, 32'hFFFFFFFF, 0, 0,  0, 32'h0));
      vt.push_back(mk(0, 0, 0,  4'h0, 32'h0,        1, 7,  1, 32'h11BB33DD));
      vt.push_back(mk(0, 1, 5,  4'hF, 32'h00000010, 0, 0,  0, 32'h0));
      vt.push_back(mk(0, 1, 5,  4'hF, 32'h00000020, 1, 5,  1, BYP ? 32'h00000020 : 32'h00000010));
      vt.push_back(mk(0, 0, 0,  4'h0, 32'h0,        1, 5,  1, 32'h00000020));
      vt.push_back(mk(0, 1, 47, 4'hF, 32'hCAFEF00D, 0, 0,  0, 32'h0));
      vt.push_back(mk(0, 1, 50, 4'hF, 32'hDEADBEEF, 0, 0,  0, 32'h0));
      vt.push_back(mk(0, 0, 0,  4'h0, 32'h0,        1, 50, 1, 32'h0));
      vt.push_back(mk(0, 0, 0,  4'h0, 32'h0,        1, 47, 1, 32'hCAFEF00D));
      vt.push_back(mk(0, 1, 2,  4'hF, 32'h12345678, 1, 3,  1, 32'h000000A5));
      vt.push_back(mk(0, 0, 0,  4'h0, 32'h0,        1, 2,  1, 32'h12345678));
      vt.push_back(mk(0, 1, 3,  4'h8, 32'h99887766, 1, 3,  1, BYP ? 32'h990000A5 : 32'h000000A5));
      vt.push_back(mk(0, 0, 0,  4'h0, 32'h0,        1, 3,  1, 32'h990000A5));
      vt.push_back(mk(0, 0, 0,  4'h0, 32'h0,        0, 3,  0, 32'h0));

      foreach (vt[k]) begin
         set_in(vt[k].clr, vt[k].we, vt[k].wa, vt[k].st, vt[k].di, vt[k].re, vt[k].ra);
         step();
         chk($sformatf("vec%0d_rv", k), DW'(r_valid), DW'(vt[k].exp_rv));
         if (vt[k].exp_rv) chk($sformatf("vec%0d_dout", k), data_out, vt[k].exp_do);
      end

      // Clear wins over a simultaneous write; then reset restarts a clear in progress.
      set_in(1'b1, 1'b1, 9, 4'hF, 32'h00000077, 1'b1, 9);
      step();
      chk("clr_accept_rv", DW'(r_valid), 32'd0);
      set_in(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
      count_busy(n);
      chk("clear_len", DW'(n), DW'(RAM_SIZE));
      set_in(1'b0, 1'b0, '0, '0, '0, 1'b1, 9);
      step();
      chk("clr_drop_write", data_out, 32'd0);

      set_in(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
      step();
      clear = 1'b0;
      repeat (19) step();
      chk("mid_clear_busy", DW'(busy), 32'd1);
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      count_busy(n);
      chk("clear_after_rst_len", DW'(n), DW'(RAM_SIZE));
      read_all_zero();

      // Held clear: one idle cycle between passes, covered by the per-cycle model check.
      clear = 1'b1;
      repeat (150) step();
      clear = 1'b0;
      count_busy(n);
      chk("held_clear_drain", DW'(busy), 32'd0);

      for (int c = 0; c < 3000; c++) begin
         logic [AW-1:0] ra;
         ra = AW'($urandom_range(0, 63));
         rst = ($urandom_range(0, 499) == 0);
         set_in($urandom_range(0, 99) == 0, 1'($urandom), ($urandom_range(0, 2) == 0) ? ra : AW'($urandom_range(0, 63)),
                NB'($urandom), $urandom, 1'($urandom), ra);
         step();
      end
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
